// File: rtl/mux2_arb_pkg.sv
// Shared constants for the two-channel packet arbiter: FSM state encoding and channel indices.
package mux2_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOCK0 = 2'd1;
    localparam state_t ST_LOCK1 = 2'd2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic state_t lock_state(input logic ch);
        return (ch == CH1) ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/mux2_out_reg.sv
// Single-entry valid/ready output register carrying data, last marker and source select.
module mux2_out_reg
    import mux2_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_sel,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    output logic              can_load
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;

    assign can_load = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
            sel_d   = load_sel;
        end else if (out_ready) begin
            // Payload fields keep their last value; only the valid flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= CH0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_sel   = sel_q;

    a_load_only_when_free: assert property (@(posedge clk) disable iff (!rst_n) load |-> can_load);

endmodule

// File: rtl/mux2_stream_arb.sv
// Round-robin packet arbiter for two valid/ready streams feeding a 2-to-1 mux; the grant is
// held for a whole packet and the chosen beat is presented through a registered output stage.
module mux2_stream_arb
    import mux2_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    input  logic              out_ready,
    output logic              busy
);

    state_t state_q, state_d;
    logic   prio_q, prio_d;
    logic   busy_q;

    logic              can_load;
    logic              grant_vld;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] acc_data;
    logic              acc_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= CH0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (!acc_last) begin
                    state_d = lock_state(grant);
                end else begin
                    prio_d = ~grant;
                end
            end else if (acc_last) begin
                state_d = ST_IDLE;
                prio_d  = ~grant;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant     = CH0;
        unique case (state_q)
            ST_LOCK0: begin
                grant_vld = 1'b1;
                grant     = CH0;
            end
            ST_LOCK1: begin
                grant_vld = 1'b1;
                grant     = CH1;
            end
            default: begin
                // Arbitration only happens between packets.
                if (in0_valid && in1_valid) begin
                    grant_vld = 1'b1;
                    grant     = prio_q;
                end else if (in0_valid) begin
                    grant_vld = 1'b1;
                    grant     = CH0;
                end else if (in1_valid) begin
                    grant_vld = 1'b1;
                    grant     = CH1;
                end
            end
        endcase

        in0_ready = rst_n && can_load && grant_vld && (grant == CH0);
        in1_ready = rst_n && can_load && grant_vld && (grant == CH1);

        if (grant == CH1) begin
            accept   = in1_valid && in1_ready;
            acc_data = in1_data;
            acc_last = in1_last;
        end else begin
            accept   = in0_valid && in0_ready;
            acc_data = in0_data;
            acc_last = in0_last;
        end
    end

    assign busy = busy_q;

    mux2_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (acc_data),
        .load_last (acc_last),
        .load_sel  (grant),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Bench for mux2_stream_arb: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a packet-level reference model.
module tb_mux2_stream_arb;

    logic       clk;
    logic       rst_n;
    logic       in0_valid, in0_last, in0_ready;
    logic [7:0] in0_data;
    logic       in1_valid, in1_last, in1_ready;
    logic [7:0] in1_data;
    logic       out_valid, out_last, out_sel, out_ready, busy;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_errs   = 0;

    mux2_stream_arb #(
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: who owns the link (-1 = nobody), round-robin pointer, output holding slot.
    int         m_lock  = -1;
    bit         m_prio  = 0;
    bit         m_ov    = 0;
    bit         m_ol    = 0;
    bit         m_os    = 0;
    bit         m_clean = 1;
    logic [7:0] m_od    = 8'h00;

    function automatic void model_grant(output bit has, output bit ch);
        has = 0;
        ch  = 0;
        if (m_lock >= 0) begin
            has = 1;
            ch  = (m_lock == 1);
        end else if (in0_valid && in1_valid) begin
            has = 1;
            ch  = m_prio;
        end else if (in0_valid) begin
            has = 1;
            ch  = 0;
        end else if (in1_valid) begin
            has = 1;
            ch  = 1;
        end
    endfunction

    function automatic void model_check();
        bit has, ch, room;
        model_grant(has, ch);
        room = !m_ov || out_ready;
        chk("in0_ready", in0_ready, rst_n && room && has && !ch);
        chk("in1_ready", in1_ready, rst_n && room && has && ch);
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, m_lock >= 0);
        if (m_ov || m_clean) begin
            chk("out_data", out_data, m_od);
            chk("out_last", out_last, m_ol);
            chk("out_sel", out_sel, m_os);
        end
    endfunction

    function automatic void model_update();
        bit has, ch, v, l;
        if (!rst_n) begin
            m_lock  = -1;
            m_prio  = 0;
            m_ov    = 0;
            m_od    = 8'h00;
            m_ol    = 0;
            m_os    = 0;
            m_clean = 1;
            return;
        end
        model_grant(has, ch);
        v = ch ? in1_valid : in0_valid;
        l = ch ? in1_last : in0_last;
        if (has && v && (!m_ov || out_ready)) begin
            m_ov    = 1;
            m_od    = ch ? in1_data : in0_data;
            m_ol    = l;
            m_os    = ch;
            m_clean = 0;
            if (m_lock < 0) begin
                if (!l) m_lock = int'(ch);
                else    m_prio = !ch;
            end else if (l) begin
                m_lock = -1;
                m_prio = !ch;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
    endfunction

    task automatic drive(input bit r, input bit v0, input logic [7:0] d0, input bit l0,
                         input bit v1, input logic [7:0] d1, input bit l1, input bit ordy);
        rst_n     = r;
        in0_valid = v0;
        in0_data  = d0;
        in0_last  = l0;
        in1_valid = v1;
        in1_data  = d1;
        in1_last  = l1;
        out_ready = ordy;
        #3;
    endtask

    task automatic tick();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         v0;
        logic [7:0] d0;
        bit         l0;
        bit         v1;
        logic [7:0] d1;
        bit         l1;
        bit         ordy;
        bit         r0;
        bit         r1;
        bit         ov;
        logic [7:0] od;
        bit         ol;
        bit         os;
        bit         bsy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Reset rows, alternating single-beat packets, then a 3-beat packet on channel 0.
        tbl[0]  = '{0, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{0, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[2]  = '{0, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[3]  = '{1, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0};
        tbl[4]  = '{1, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 1, 1, 8'hA0, 1, 0, 0};
        tbl[5]  = '{1, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 1, 0, 1, 8'hB1, 1, 1, 0};
        tbl[6]  = '{1, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 1, 1, 8'hA0, 1, 0, 0};
        tbl[7]  = '{1, 1, 8'h10, 0, 1, 8'hB1, 1, 1, 1, 0, 1, 8'hB1, 1, 1, 0};
        tbl[8]  = '{1, 1, 8'h11, 0, 1, 8'hB1, 1, 1, 1, 0, 1, 8'h10, 0, 0, 1};
        tbl[9]  = '{1, 1, 8'h12, 1, 1, 8'hB1, 1, 1, 1, 0, 1, 8'h11, 0, 0, 1};
        tbl[10] = '{1, 1, 8'h13, 1, 1, 8'hB1, 1, 1, 0, 1, 1, 8'h12, 1, 0, 0};
        tbl[11] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hB1, 1, 1, 0};
        tbl[12] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};

        drive(0, 1, 8'hA0, 1, 1, 8'hB1, 1, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].l0,
                  tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].ordy);
            chk($sformatf("tbl%0d in0_ready", i), in0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d in1_ready", i), in1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d busy", i), busy, tbl[i].bsy);
            if (tbl[i].ov || i <= 3) begin
                chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].od);
                chk($sformatf("tbl%0d out_last", i), out_last, tbl[i].ol);
                chk($sformatf("tbl%0d out_sel", i), out_sel, tbl[i].os);
            end
            tick();
        end

        // Backpressure: 5C sits in the output while downstream stalls for 4 cycles.
        drive(1, 1, 8'h5C, 1, 0, 8'h00, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h5D, 1, 1, 8'hB1, 1, 0);
            chk("bp out_data", out_data, 8'h5C);
            chk("bp out_valid", out_valid, 1'b1);
            chk("bp in0_ready", in0_ready, 1'b0);
            chk("bp in1_ready", in1_ready, 1'b0);
            tick();
        end
        drive(1, 1, 8'h5D, 1, 1, 8'hB1, 1, 1);
        chk("bp release in1_ready", in1_ready, 1'b1);
        tick();

        // Valid gap inside a channel 1 packet keeps channel 0 locked out.
        drive(1, 0, 8'h00, 0, 1, 8'h20, 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 8'h40, 1, 0, 8'h00, 0, 1);
            chk("gap in0_ready", in0_ready, 1'b0);
            chk("gap in1_ready", in1_ready, 1'b1);
            chk("gap busy", busy, 1'b1);
            tick();
        end
        drive(1, 1, 8'h40, 1, 1, 8'h21, 1, 1);
        chk("gap last in0_ready", in0_ready, 1'b0);
        tick();
        drive(1, 1, 8'h40, 1, 1, 8'h22, 1, 1);
        chk("gap done busy", busy, 1'b0);
        chk("gap done out_data", out_data, 8'h21);
        chk("gap done in0_ready", in0_ready, 1'b1);
        tick();

        // Reset in the middle of a channel 0 packet.
        drive(1, 1, 8'h30, 0, 0, 8'h00, 0, 1);
        tick();
        drive(0, 1, 8'h31, 0, 1, 8'hB1, 1, 1);
        chk("rst mid busy", busy, 1'b1);
        chk("rst mid in0_ready", in0_ready, 1'b0);
        chk("rst mid in1_ready", in1_ready, 1'b0);
        tick();
        drive(1, 1, 8'h31, 1, 1, 8'hB1, 1, 1);
        chk("post rst busy", busy, 1'b0);
        chk("post rst out_valid", out_valid, 1'b0);
        chk("post rst out_data", out_data, 8'h00);
        chk("post rst in0_ready", in0_ready, 1'b1);
        chk("post rst in1_ready", in1_ready, 1'b0);
        tick();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) != 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
